// File: rtl/uart_crc_frame_receiver.sv
// uart_crc_frame_receiver: UART frame receiver (start, data, CRC, stop) with serial CRC check.
// Ports:
//   clk, reset_n (async active-low)  system clock and reset
//   rx_in                            serial line, idle high, asynchronous to clk
//   data_out / crc_out               received payload and CRC field, bit 0 = first received
//   crc_err / frame_err              CRC mismatch / stop bit low, valid with out_valid
//   out_valid / out_ready            downstream handshake, frame held until accepted
//   overrun                          one-cycle pulse when a completed frame is dropped
module uart_crc_frame_receiver #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int CRC_BITS = 8,
  parameter logic [CRC_BITS-1:0] CRC_POLY = CRC_BITS'(8'h07),
  parameter logic [CRC_BITS-1:0] CRC_INIT = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic [CRC_BITS-1:0]  crc_out,
  output logic                 crc_err,
  output logic                 frame_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(DIV);
  localparam int NB = DATA_BITS > CRC_BITS ? DATA_BITS : CRC_BITS;
  localparam int BW = $clog2(NB + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, CRC, STOP} state_t;
  state_t state, state_nx;
  logic s1, rxs;
  logic [CW-1:0] cnt;
  logic [BW-1:0] nb;
  logic [DATA_BITS-1:0] data_sr, data_nx;
  logic [CRC_BITS-1:0] crc_sr, lfsr, lfsr_nx;
  logic stop_bit, done, tick, last;
  // tick marks the sampling point: half a bit into START, mid-bit afterwards
  always_comb begin
    tick = state == START ? cnt == CW'(DIV/2-1) : (state != IDLE && cnt == CW'(DIV-1));
    last = state == DATA ? nb == BW'(DATA_BITS-1) : nb == BW'(CRC_BITS-1);
    state_nx = state;
    case (state)
      IDLE:    if (!rxs) state_nx = START;
      START:   if (tick) state_nx = rxs ? IDLE : DATA;
      DATA:    if (tick && last) state_nx = CRC;
      CRC:     if (tick && last) state_nx = STOP;
      STOP:    if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    data_nx = data_sr >> 1;
    data_nx[DATA_BITS-1] = rxs;
    lfsr_nx = {lfsr[CRC_BITS-2:0], 1'b0} ^ ((lfsr[CRC_BITS-1] ^ rxs) ? CRC_POLY : '0);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1 <= rx_in;
      rxs <= s1;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      nb <= '0;
      data_sr <= '0;
      crc_sr <= '0;
      lfsr <= '0;
      stop_bit <= 1'b0;
      done <= 1'b0;
      data_out <= '0;
      crc_out <= '0;
      crc_err <= 1'b0;
      frame_err <= 1'b0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      nb <= (state == IDLE || state == START || (tick && last)) ? '0 : tick ? nb + BW'(1) : nb;
      if (tick && state == DATA) data_sr <= data_nx;
      lfsr <= state == START ? CRC_INIT : (tick && state == DATA) ? lfsr_nx : lfsr;
      if (tick && state == CRC) crc_sr <= {rxs, crc_sr[CRC_BITS-1:1]};
      if (tick && state == STOP) stop_bit <= rxs;
      done <= tick && state == STOP;
      // a completed frame is dropped only if the held one is not leaving this cycle
      overrun <= done && out_valid && !out_ready;
      if (done && (!out_valid || out_ready)) begin
        data_out <= data_sr;
        crc_out <= crc_sr;
        crc_err <= crc_sr != lfsr;
        frame_err <= ~stop_bit;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule
